sdram_rd_arbiter: RTL and testbench
===================================

// Module: sdram_rd_arbiter
// PURPOSE
// - Shares the single SDRAM read port (rd_req/rd_address in, 128-bit rd_data/rd_data_valid out)
//   between NUM_REQ read clients (display reader, HDR merge engine, UART dump controller).
// - Each client uses the existing pulse protocol: wait for its busy low, pulse rd_req with an address,
//   then wait for rd_data_valid. One read is outstanding at the SDRAM at a time.
// - Round-robin grant by default. A watchdog prevents a lost read from hanging any client.
// PARAMETERS
// - NUM_REQ         3     number of read clients; index 0 is the display reader
// - ADDR_W          25    SDRAM word address width
// - DATA_W          128   read burst data width
// - TIMEOUT_CYCLES  4096  cycles in WAIT_DATA before the read is abandoned
// PORTS
// - clk              in   1               system clock
// - rst_n            in   1               asynchronous active-low reset
// - req_rd_req       in   NUM_REQ         per-client 1-cycle read request pulse
// - req_rd_address   in   NUM_REQ*ADDR_W  per-client address, client i at [i*ADDR_W +: ADDR_W]
// - req_busy         out  NUM_REQ         client i must not pulse while high (registered)
// - req_rd_data      out  DATA_W          shared return data, valid only with its req_rd_data_valid bit
// - req_rd_data_valid out NUM_REQ         1-cycle one-hot return strobe to the owning client
// - rd_req           out  1               1-cycle request pulse to the SDRAM controller
// - rd_address       out  ADDR_W          address held stable from rd_req until the next grant
// - rd_data          in   DATA_W          SDRAM read data
// - rd_data_valid    in   1               SDRAM read data strobe
// - ram_busy         in   1               SDRAM controller cannot accept rd_req
// - timeout_err      out  1               sticky; set on any watchdog expiry, cleared only by reset
// BEHAVIOUR
// - Reset (async): all outputs 0, pending=0, owner=0, rr_ptr=NUM_REQ-1, wd_cnt=0, STATE=IDLE.
// - Capture: at the edge where req_rd_req[i]=1 and pending[i]=0 and client i is not the owner in
//   WAIT_DATA, set pending[i] and latch its address. Pulses while req_busy[i]=1 are ignored.
// - req_busy[i] <= next pending[i] | (i==next owner & next STATE==WAIT_DATA), so busy is high from the
//   cycle after the pulse until the cycle after that client's valid strobe.
// - IDLE: if |pending and ~ram_busy, pick winner w, drive rd_req=1 for one cycle, set rd_address=addr[w],
//   owner=w, clear pending[w], wd_cnt=0, go to WAIT_DATA. Otherwise rd_req=0 and stay in IDLE.
// - Latency: client pulse at edge k sets pending at k. rd_req is high after edge k+1 when ram_busy=0
//   and no other read is in flight.
// - WAIT_DATA: rd_req=0 and wd_cnt increments each cycle. On rd_data_valid, register rd_data into
//   req_rd_data, pulse req_rd_data_valid[owner] for 1 cycle, set rr_ptr=owner, go to IDLE.
//   The earliest next grant is the following cycle.
// - Watchdog: if wd_cnt reaches TIMEOUT_CYCLES-1 without valid, deliver req_rd_data=0 with a
//   req_rd_data_valid[owner] pulse, set timeout_err, set rr_ptr=owner, go to IDLE.
// - If rd_data_valid arrives in the same cycle as expiry, the real data wins and timeout_err is not set.
// - rd_data_valid in IDLE (spurious or late after timeout) is ignored; no client strobe.
// - Round-robin: search pending from rr_ptr+1 upward, wrapping at NUM_REQ-1 to 0. The first set bit wins.
// - A new pulse from client j in the same cycle as a grant to client i (j!=i) is captured normally.
// - Clients whose pulse lands in a grant cycle of another client are served in order without loss.
// CONFIGURATION
// - SDRAM_ARB_FIXED_PRIO_EN defined: client 0 (display) always wins when pending; clients 1..NUM_REQ-1
//   round-robin among themselves only when pending[0]=0. rr_ptr is updated only on grants to clients >=1.
// - Not defined: pure round-robin over all clients as above.
// TESTING
// - Reset, client 2 pulses addr 0x70800, ram_busy=0 -> rd_req 2 clocks later with rd_address=0x70800.
//   Return valid with data D -> req_rd_data_valid=3'b100, req_rd_data=D, req_busy[2] low next cycle.
// - Clients 0,1,2 pulse together, each valid returned 5 cycles after its rd_req -> grant order 0,1,2.
//   Repeat immediately -> order 0,1,2 again (rr_ptr wraps from 2).
// - ram_busy=1 for 20 cycles with client 1 pending -> no rd_req. rd_req follows the cycle after
//   ram_busy falls; req_busy[1] stays high throughout.
// - No rd_data_valid after a grant -> strobe with data 0 after 4096 cycles and timeout_err=1.
//   A later valid in IDLE produces no client strobe.
// - rst_n dropped mid-WAIT_DATA with clients 0,1 pending -> all outputs 0 immediately. After release,
//   stale pending is gone and a late valid is ignored.
// - With SDRAM_ARB_FIXED_PRIO_EN, client 0 re-pulses after every return while 1,2 pending ->
//   client 0 always wins. Clients 1 and 2 are served only in gaps and alternate 1,2.

Source files
------------

// File: rtl/sdram_rd_arbiter.sv
// Read-port arbiter sharing one SDRAM read channel between NUM_REQ pulse-protocol clients.
// Optional macro SDRAM_ARB_FIXED_PRIO_EN: client 0 gets absolute priority, the rest round-robin.
module sdram_rd_arbiter #(
    parameter int unsigned NUM_REQ        = 3,
    parameter int unsigned ADDR_W         = 25,
    parameter int unsigned DATA_W         = 128,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_rd_req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd_address,
    output logic [NUM_REQ-1:0]        req_busy,
    output logic [DATA_W-1:0]         req_rd_data,
    output logic [NUM_REQ-1:0]        req_rd_data_valid,
    output logic                      rd_req,
    output logic [ADDR_W-1:0]         rd_address,
    input  logic [DATA_W-1:0]         rd_data,
    input  logic                      rd_data_valid,
    input  logic                      ram_busy,
    output logic                      timeout_err
);
    localparam int unsigned OW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, WAIT_DATA} state_t;

    state_t              state;
    logic [NUM_REQ-1:0]  pending;
    logic [NUM_REQ-1:0]  capture;
    logic [NUM_REQ-1:0]  pend_nxt;
    logic [NUM_REQ-1:0]  busy_nxt;
    logic [ADDR_W-1:0]   addr_q [NUM_REQ];
    logic [OW-1:0]       owner;
    logic [OW-1:0]       rr_ptr;
    logic [OW-1:0]       win;
    logic                found;
    logic                grant;
    logic                expire;
    logic                done;
    logic [WD_W-1:0]     wd_cnt;
    int unsigned         idx;

    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        if (pending[0]) begin
            found = 1'b1;
        end else begin
            // Rotating search over clients 1..NUM_REQ-1 starting after rr_ptr
            for (int unsigned k = 1; k < NUM_REQ; k++) begin
                idx = ((32'(rr_ptr) + NUM_REQ - 2 + k) % (NUM_REQ - 1)) + 1;
                if (!found && pending[idx]) begin
                    win   = OW'(idx);
                    found = 1'b1;
                end
            end
        end
`else
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!found && pending[idx]) begin
                win   = OW'(idx);
                found = 1'b1;
            end
        end
`endif
        grant  = (state == IDLE) && found && !ram_busy;
        expire = (state == WAIT_DATA) && !rd_data_valid && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
        done   = (state == WAIT_DATA) && (rd_data_valid || expire);

        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            capture[i] = req_rd_req[i] && !pending[i] && !((state == WAIT_DATA) && (owner == OW'(i)));
        end
        pend_nxt = pending | capture;
        if (grant) begin
            pend_nxt[win] = 1'b0;
        end
        // Busy mirrors next-cycle pending plus the owner of an in-flight read
        busy_nxt = pend_nxt;
        if (grant) begin
            busy_nxt[win] = 1'b1;
        end else if ((state == WAIT_DATA) && !done) begin
            busy_nxt[owner] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            pending           <= '0;
            owner             <= '0;
            rr_ptr            <= OW'(NUM_REQ - 1);
            wd_cnt            <= '0;
            req_busy          <= '0;
            req_rd_data       <= '0;
            req_rd_data_valid <= '0;
            rd_req            <= 1'b0;
            rd_address        <= '0;
            timeout_err       <= 1'b0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            rd_req            <= grant;
            req_rd_data_valid <= '0;
            pending           <= pend_nxt;
            req_busy          <= busy_nxt;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (capture[i]) begin
                    addr_q[i] <= req_rd_address[i*ADDR_W +: ADDR_W];
                end
            end
            case (state)
                IDLE: begin
                    if (grant) begin
                        rd_address <= addr_q[win];
                        owner      <= win;
                        wd_cnt     <= '0;
                        state      <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (done) begin
                        req_rd_data              <= rd_data_valid ? rd_data : '0;
                        req_rd_data_valid[owner] <= 1'b1;
                        if (expire) begin
                            timeout_err <= 1'b1;
                        end
`ifdef SDRAM_ARB_FIXED_PRIO_EN
                        if (owner != '0) begin
                            rr_ptr <= owner;
                        end
`else
                        rr_ptr <= owner;
`endif
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_rd_arbiter.sv
// Directed self-checking bench for sdram_rd_arbiter: grant order, latency, ram_busy stall,
// watchdog expiry and race, async reset mid-read, and fixed priority when that macro is set.
module tb_sdram_rd_arbiter;
    localparam int unsigned N  = 3;
    localparam int unsigned AW = 25;
    localparam int unsigned DW = 128;
    localparam int unsigned TO = 4096;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_rd_req = '0;
    logic [N*AW-1:0] req_rd_address = '0;
    logic [N-1:0]    req_busy;
    logic [DW-1:0]   req_rd_data;
    logic [N-1:0]    req_rd_data_valid;
    logic            rd_req;
    logic [AW-1:0]   rd_address;
    logic [DW-1:0]   rd_data = '0;
    logic            rd_data_valid = 1'b0;
    logic            ram_busy = 1'b0;
    logic            timeout_err;

    int checks = 0;
    int failures = 0;

    sdram_rd_arbiter #(
        .NUM_REQ(N),
        .ADDR_W(AW),
        .DATA_W(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_rd_req(req_rd_req),
        .req_rd_address(req_rd_address),
        .req_busy(req_busy),
        .req_rd_data(req_rd_data),
        .req_rd_data_valid(req_rd_data_valid),
        .rd_req(rd_req),
        .rd_address(rd_address),
        .rd_data(rd_data),
        .rd_data_valid(rd_data_valid),
        .ram_busy(ram_busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [N-1:0] mask, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2);
        req_rd_address = {a2, a1, a0};
        req_rd_req     = mask;
        tick();
        req_rd_req     = '0;
    endtask

    task automatic wait_rd_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (rd_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic give_data(input logic [DW-1:0] d);
        rd_data       = d;
        rd_data_valid = 1'b1;
        tick();
        rd_data_valid = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({req_busy, req_rd_data_valid, rd_req, timeout_err} !== '0 || rd_address !== '0 || req_rd_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b valid=%b rd_req=%b terr=%b addr=%h data=%h required all 0",
                     req_busy, req_rd_data_valid, rd_req, timeout_err, rd_address, req_rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single;
        logic [DW-1:0] d;
        d = {4{32'hCAFE_0123}};
        pulse(3'b100, '0, '0, 25'h0070800);
        checks++;
        if (rd_req !== 1'b0 || req_busy !== 3'b100) begin
            failures++;
            $display("FAIL single_capture: rd_req=%b busy=%b required 0 / 100", rd_req, req_busy);
        end
        tick();
        checks++;
        if (rd_req !== 1'b1 || rd_address !== 25'h0070800) begin
            failures++;
            $display("FAIL single_grant: rd_req=%b addr=%h required 1 / 0070800", rd_req, rd_address);
        end
        tick();
        checks++;
        if (rd_req !== 1'b0 || req_busy !== 3'b100) begin
            failures++;
            $display("FAIL single_wait: rd_req=%b busy=%b required 0 / 100", rd_req, req_busy);
        end
        give_data(d);
        checks++;
        if (req_rd_data_valid !== 3'b100 || req_rd_data !== d || req_busy !== 3'b000) begin
            failures++;
            $display("FAIL single_return: valid=%b data=%h busy=%b required 100 / %h / 000",
                     req_rd_data_valid, req_rd_data, req_busy, d);
        end
        tick();
        checks++;
        if (req_rd_data_valid !== 3'b000) begin
            failures++;
            $display("FAIL single_strobe_len: valid=%b required 000", req_rd_data_valid);
        end
    endtask

    task automatic test_round_robin;
        logic [AW-1:0] a [N];
        logic [N-1:0]  exp_v;
        logic [DW-1:0] d;
        bit ok;
        a[0] = 25'h0001000;
        a[1] = 25'h0123456;
        a[2] = 25'h1ABCDEF;
        for (int r = 0; r < 2; r++) begin
            pulse(3'b111, a[0], a[1], a[2]);
            checks++;
            if (req_busy !== 3'b111) begin
                failures++;
                $display("FAIL rr_busy round %0d: busy=%b required 111", r, req_busy);
            end
            for (int c = 0; c < int'(N); c++) begin
                wait_rd_req(ok);
                checks++;
                if (!ok || rd_address !== a[c]) begin
                    failures++;
                    $display("FAIL rr_grant round %0d slot %0d: rd_req_seen=%0d addr=%h required 1 / %h",
                             r, c, ok, rd_address, a[c]);
                end
                repeat (4) tick();
                d = DW'(32'hA000 + r * 16 + c);
                give_data(d);
                exp_v = N'(1) << c;
                checks++;
                if (req_rd_data_valid !== exp_v || req_rd_data !== d) begin
                    failures++;
                    $display("FAIL rr_return round %0d slot %0d: valid=%b data=%h required %b / %h",
                             r, c, req_rd_data_valid, req_rd_data, exp_v, d);
                end
            end
        end
    endtask

    task automatic test_ram_busy;
        logic [DW-1:0] d;
        d = {2{64'h0BAD_F00D_1234_5678}};
        ram_busy = 1'b1;
        pulse(3'b010, '0, 25'h0055AA0, '0);
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (rd_req !== 1'b0 || req_busy[1] !== 1'b1) begin
                failures++;
                $display("FAIL ram_busy_stall cycle %0d: rd_req=%b busy1=%b required 0 / 1", k, rd_req, req_busy[1]);
            end
            tick();
        end
        ram_busy = 1'b0;
        tick();
        checks++;
        if (rd_req !== 1'b1 || rd_address !== 25'h0055AA0 || req_busy[1] !== 1'b1) begin
            failures++;
            $display("FAIL ram_busy_release: rd_req=%b addr=%h busy1=%b required 1 / 0055AA0 / 1",
                     rd_req, rd_address, req_busy[1]);
        end
        tick();
        give_data(d);
        checks++;
        if (req_rd_data_valid !== 3'b010 || req_rd_data !== d) begin
            failures++;
            $display("FAIL ram_busy_return: valid=%b data=%h required 010 / %h", req_rd_data_valid, req_rd_data, d);
        end
    endtask

    task automatic test_timeout_race;
        logic [DW-1:0] d;
        bit ok;
        d = {4{32'h7777_1111}};
        pulse(3'b001, 25'h0000ABC, '0, '0);
        wait_rd_req(ok);
        repeat (TO - 1) tick();
        give_data(d);
        checks++;
        if (!ok || req_rd_data_valid !== 3'b001 || req_rd_data !== d || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_race: grant=%0d valid=%b data=%h terr=%b required 1 / 001 / %h / 0",
                     ok, req_rd_data_valid, req_rd_data, timeout_err, d);
        end
    endtask

    task automatic test_timeout;
        bit ok;
        bit seen;
        int n;
        seen = 1'b0;
        n = 0;
        pulse(3'b001, 25'h0000DEF, '0, '0);
        wait_rd_req(ok);
        for (int k = 1; k <= int'(TO) + 100; k++) begin
            tick();
            if (req_rd_data_valid !== 3'b000) begin
                n = k;
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || !seen || n != int'(TO)) begin
            failures++;
            $display("FAIL timeout_latency: grant=%0d seen=%0d cycles=%0d required 1 / 1 / %0d", ok, seen, n, TO);
        end
        checks++;
        if (req_rd_data_valid !== 3'b001 || req_rd_data !== '0 || timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_strobe: valid=%b data=%h terr=%b required 001 / 0 / 1",
                     req_rd_data_valid, req_rd_data, timeout_err);
        end
        give_data({4{32'hFFFF_0000}});
        checks++;
        if (req_rd_data_valid !== 3'b000 || rd_req !== 1'b0) begin
            failures++;
            $display("FAIL late_valid_idle: valid=%b rd_req=%b required 000 / 0", req_rd_data_valid, rd_req);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        pulse(3'b100, '0, '0, 25'h0000444);
        wait_rd_req(ok);
        pulse(3'b011, 25'h0000111, 25'h0000222, 25'h0000444);
        checks++;
        if (!ok || req_busy !== 3'b111) begin
            failures++;
            $display("FAIL reset_mid_setup: grant=%0d busy=%b required 1 / 111", ok, req_busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_busy, req_rd_data_valid, rd_req, timeout_err} !== '0 || rd_address !== '0 || req_rd_data !== '0) begin
            failures++;
            $display("FAIL reset_mid_async: busy=%b valid=%b rd_req=%b terr=%b addr=%h required all 0",
                     req_busy, req_rd_data_valid, rd_req, timeout_err, rd_address);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (rd_req !== 1'b0 || req_busy !== 3'b000) begin
                failures++;
                $display("FAIL reset_mid_stale cycle %0d: rd_req=%b busy=%b required 0 / 000", k, rd_req, req_busy);
            end
        end
        give_data({4{32'h5555_AAAA}});
        checks++;
        if (req_rd_data_valid !== 3'b000) begin
            failures++;
            $display("FAIL reset_mid_late_valid: valid=%b required 000", req_rd_data_valid);
        end
    endtask

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio;
        logic [AW-1:0] a [N];
        int seq [5];
        logic [N-1:0] exp_v;
        logic [DW-1:0] d;
        bit ok;
        a[0] = 25'h0000010;
        a[1] = 25'h0000020;
        a[2] = 25'h0000030;
        seq = '{0, 1, 0, 2, 0};
        pulse(3'b111, a[0], a[1], a[2]);
        for (int s = 0; s < 5; s++) begin
            wait_rd_req(ok);
            checks++;
            if (!ok || rd_address !== a[seq[s]]) begin
                failures++;
                $display("FAIL fixed_grant slot %0d: rd_req_seen=%0d addr=%h required 1 / %h", s, ok, rd_address, a[seq[s]]);
            end
            repeat (2) tick();
            d = DW'(32'hF000 + s);
            give_data(d);
            exp_v = N'(1) << seq[s];
            checks++;
            if (req_rd_data_valid !== exp_v || req_rd_data !== d) begin
                failures++;
                $display("FAIL fixed_return slot %0d: valid=%b data=%h required %b / %h", s, req_rd_data_valid, req_rd_data, exp_v, d);
            end
            if (seq[s] == 0 && s < 4) pulse(3'b001, a[0], a[1], a[2]);
        end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_ram_busy();
        test_timeout_race();
        test_timeout();
        test_reset_mid();
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
